vmm_job_arb: RTL and testbench
==============================

# vmm_job_arb

Round-robin job scheduler that shares one vector-matrix-multiply engine among NREQ requesters. It accepts job descriptors (l, n, m loop bounds), grants the engine to one requester at a time and issues a start pulse. It routes the engine's output strobes back to the owner and returns a done or error pulse. A watchdog aborts jobs that stall. The block sits between the requester ports and the VMM engine's control/sequencer.

## Interface
- NREQ, 4: number of requesters (2..8)
- DIM_W, 4: width of each loop bound l, n, m
- TIMEOUT, 1024: max RUN cycles before abort (≥ 2)
- clk  in  1  rising-edge clock, sole clock domain
- rst_  in  1  reset; synchronous, active-high
- req  in  NREQ  per-requester job request level
- req_dim  in  NREQ*3*DIM_W  descriptor per requester r at [r*3*DIM_W +: 3*DIM_W], packed {l, n, m}
- gnt  out  NREQ  one-hot owner indication
- done  out  NREQ  one-cycle completion pulse to owner
- err  out  NREQ  one-cycle error pulse (zero dimension or timeout)
- out_valid  out  NREQ  eng_out_valid demuxed to owner
- eng_start  out  1  one-cycle engine launch pulse
- eng_abort  out  1  one-cycle engine abort pulse
- eng_l, eng_n, eng_m  out  DIM_W each  latched bounds, stable from LAUNCH to RESP
- eng_done  in  1  engine completion pulse
- eng_out_valid  in  1  engine output strobe

## Operation
- States: IDLE, LAUNCH, RUN, ABORT, RESP.
- IDLE: if any req is set, select the winner by round-robin starting at ptr+1 mod NREQ.
  - Latch owner index and its descriptor. Update ptr to the winner.
  - If any of l, n, m is 0: set err_flag and go to RESP (no launch). Otherwise go to LAUNCH.
- LAUNCH: eng_start=1; clear the watchdog; go to RUN.
- RUN:
  - out_valid[owner]=eng_out_valid; all other out_valid bits are 0.
  - If eng_done: go to RESP with err_flag=0.
  - Else if wdog==TIMEOUT-1: go to ABORT.
  - Else wdog++.
- ABORT: eng_abort=1; set err_flag; go to RESP.
- RESP:
  - done[owner]=!err_flag and err[owner]=err_flag, for one cycle.
  - Go to IDLE.
- gnt[owner]=1 in LAUNCH, RUN, ABORT and RESP, and also for the single RESP cycle of a zero-dimension reject. gnt=0 in IDLE.
- Requester protocol:
  - Hold req and req_dim stable until done or err.
  - Deassert req in the cycle after the pulse, or keep it high to queue another job.
  - A req dropped mid-job is ignored; the job still runs to completion.
- eng_done is ignored outside RUN. eng_out_valid is ignored outside RUN.
- Simultaneous eng_done and watchdog expiry in RUN: done wins, no abort.
- Fairness: a requester that holds req waits at most NREQ-1 other jobs.

## Timing
- Reset values:
  - state=IDLE, ptr=NREQ-1 (so requester 0 has first priority), wdog=0, owner=0, err_flag=0.
  - All outputs 0: gnt, done, err, out_valid, eng_start, eng_abort, and eng_l/n/m.
- Latency, with req sampled in IDLE at cycle t:
  - gnt and eng_start at t+1.
  - RUN from t+2.
  - eng_done sampled at cycle u gives done at u+1 and IDLE at u+2.
  - Earliest re-arbitration is at u+2.
- Zero-dimension reject: err and gnt at t+1, IDLE at t+2.
- Timeout: with RUN entered at cycle r and no eng_done, eng_abort fires at r+TIMEOUT and err at r+TIMEOUT+1.
- Reset mid-operation: returns to IDLE next edge with all outputs 0 and no done/err emitted. The engine is reset on the same rst_.
- All outputs are registered-state decodes, so there is no combinational path from req to gnt.
- out_valid is combinational from eng_out_valid, gated by state and owner.
- wdog width is clog2(TIMEOUT).

## Structure
- Shared package vmm_pkg holds:
  - state encoding localparams (IDLE, LAUNCH, RUN, ABORT, RESP);
  - descriptor field offsets;
  - the DIM_W default.
- Sub-module rr_pick (NREQ): combinational round-robin priority picker. Inputs req and ptr; outputs winner index and any_req. It is reusable by other shared-resource blocks.
- The FSM, owner/descriptor registers, watchdog and output demux live in vmm_job_arb.

## Test plan
- Single requester 2 with {l,n,m}={3,2,4}:
  - gnt=4'b0100 and eng_start one cycle after req, with eng_l/n/m=3/2/4.
  - eng_done → done[2] one cycle later, then gnt=0.
- All four req held high from reset, each eng_done 5 cycles after start: grant order 0,1,2,3,0; every eng_start is exactly one cycle wide.
- Requester 1 with n=0: err[1] pulse one cycle after req, no eng_start, ptr advances so requester 2 is next.
- TIMEOUT=8, eng_done never asserted: eng_abort 8 cycles after RUN entry, err[owner] the next cycle, no done.
- eng_done coincident with the final watchdog cycle: done pulse, no eng_abort, no err.
- rst_ asserted in RUN while eng_out_valid toggles: next cycle all outputs are 0 and state=IDLE; after release, requester 0 wins first.

Source files
------------

// File: rtl/vmm_pkg.sv
// Shared definitions for the VMM job arbiter: FSM encoding, descriptor layout
// and the default loop-bound width.
package vmm_pkg;

  localparam int DIM_W_DEF   = 4;
  localparam int DESC_FIELDS = 3;

  // Field slot within a packed {l, n, m} descriptor, in units of DIM_W.
  localparam int L_OFF = 2;
  localparam int N_OFF = 1;
  localparam int M_OFF = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_ABORT  = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/vmm_job_arb_if.sv
// Requester-side and engine-side signals of the VMM job arbiter. The arbiter
// takes the slave view; requesters and the engine together form the master.
interface vmm_job_arb_if
  import vmm_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DIM_W = DIM_W_DEF
);

  logic [NREQ-1:0]                  req;
  logic [NREQ*DESC_FIELDS*DIM_W-1:0] req_dim;
  logic [NREQ-1:0]                  gnt;
  logic [NREQ-1:0]                  done;
  logic [NREQ-1:0]                  err;
  logic [NREQ-1:0]                  out_valid;
  logic                             eng_start;
  logic                             eng_abort;
  logic [DIM_W-1:0]                 eng_l;
  logic [DIM_W-1:0]                 eng_n;
  logic [DIM_W-1:0]                 eng_m;
  logic                             eng_done;
  logic                             eng_out_valid;

  modport master (
    output req, req_dim, eng_done, eng_out_valid,
    input  gnt, done, err, out_valid, eng_start, eng_abort, eng_l, eng_n, eng_m
  );

  modport slave (
    input  req, req_dim, eng_done, eng_out_valid,
    output gnt, done, err, out_valid, eng_start, eng_abort, eng_l, eng_n, eng_m
  );

endinterface

// File: rtl/vmm_job_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr+1,
// wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_any_req
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_winner  = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    // Scan from the farthest candidate down so the nearest one after ptr wins last.
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = IDX_W'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_idx]) begin
        o_winner  = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmm_job_arb.sv
// Round-robin job scheduler sharing one VMM engine among NREQ requesters,
// with zero-dimension rejection and a RUN-state watchdog.
module vmm_job_arb
  import vmm_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIM_W   = DIM_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_,
  vmm_job_arb_if.slave  bus
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int WD_W   = $clog2(TIMEOUT);
  localparam int DESC_W = DESC_FIELDS * DIM_W;

  state_e           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [WD_W-1:0]  r_wdog;
  logic             r_err_flag;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic [NREQ-1:0]  r_err;
  logic             r_eng_start;
  logic             r_eng_abort;
  logic [DIM_W-1:0] r_eng_l;
  logic [DIM_W-1:0] r_eng_n;
  logic [DIM_W-1:0] r_eng_m;

  logic [IDX_W-1:0]  w_winner;
  logic              w_any_req;
  logic [DESC_W-1:0] w_desc;
  logic [DIM_W-1:0]  w_l;
  logic [DIM_W-1:0]  w_n;
  logic [DIM_W-1:0]  w_m;
  logic              w_zero_dim;
  logic [NREQ-1:0]   w_win_onehot;
  logic [NREQ-1:0]   w_own_onehot;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req     (bus.req),
    .i_ptr     (r_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_desc       = bus.req_dim[w_winner*DESC_W +: DESC_W];
  assign w_l          = w_desc[L_OFF*DIM_W +: DIM_W];
  assign w_n          = w_desc[N_OFF*DIM_W +: DIM_W];
  assign w_m          = w_desc[M_OFF*DIM_W +: DIM_W];
  assign w_zero_dim   = (w_l == '0) || (w_n == '0) || (w_m == '0);
  assign w_win_onehot = NREQ'(1) << w_winner;
  assign w_own_onehot = NREQ'(1) << r_owner;

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state     <= ST_IDLE;
      r_ptr       <= IDX_W'(NREQ - 1);
      r_owner     <= '0;
      r_wdog      <= '0;
      r_err_flag  <= 1'b0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      r_eng_l     <= '0;
      r_eng_n     <= '0;
      r_eng_m     <= '0;
    end else begin
      // NOTE: non-blocking defaults here make every pulse one cycle; a later
      // assignment in the case below overrides them for that edge only.
      r_eng_start <= 1'b0;
      r_eng_abort <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_ptr   <= w_winner;
            r_eng_l <= w_l;
            r_eng_n <= w_n;
            r_eng_m <= w_m;
            r_gnt   <= w_win_onehot;
            if (w_zero_dim) begin
              r_err_flag <= 1'b1;
              r_err      <= w_win_onehot;
              r_state    <= ST_RESP;
            end else begin
              r_err_flag  <= 1'b0;
              r_eng_start <= 1'b1;
              r_state     <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          r_wdog  <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // A done arriving on the last watchdog cycle still counts as success.
          if (bus.eng_done) begin
            r_err_flag <= 1'b0;
            r_done     <= w_own_onehot;
            r_state    <= ST_RESP;
          end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
            r_eng_abort <= 1'b1;
            r_state     <= ST_ABORT;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_ABORT: begin
          r_err_flag <= 1'b1;
          r_err      <= w_own_onehot;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_gnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.eng_start = r_eng_start;
  assign bus.eng_abort = r_eng_abort;
  assign bus.eng_l     = r_eng_l;
  assign bus.eng_n     = r_eng_n;
  assign bus.eng_m     = r_eng_m;
  assign bus.out_valid = (r_state == ST_RUN && bus.eng_out_valid) ? w_own_onehot : '0;

endmodule

// File: tb/tb_vmm_job_arb.sv
// Directed bench for vmm_job_arb (NREQ=4, DIM_W=4, TIMEOUT=8); inputs change
// and outputs are sampled 1 time unit after each rising edge.
module tb_vmm_job_arb;

  localparam int NREQ    = 4;
  localparam int DIM_W   = 4;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst_;
  int   tests;
  int   fails;

  vmm_job_arb_if #(.NREQ(NREQ), .DIM_W(DIM_W)) bus ();

  vmm_job_arb #(.NREQ(NREQ), .DIM_W(DIM_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dim(input int r, input logic [3:0] l, input logic [3:0] n, input logic [3:0] m);
    bus.req_dim[r*12 +: 12] = {l, n, m};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"},       32'(bus.gnt),       32'h0);
    check({tag, ".done"},      32'(bus.done),      32'h0);
    check({tag, ".err"},       32'(bus.err),       32'h0);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'h0);
    check({tag, ".eng_start"}, 32'(bus.eng_start), 32'h0);
    check({tag, ".eng_abort"}, 32'(bus.eng_abort), 32'h0);
    check({tag, ".eng_lnm"},   32'({bus.eng_l, bus.eng_n, bus.eng_m}), 32'h0);
  endtask

  initial begin
    int order [5];
    tests = 0;
    fails = 0;
    order = '{0, 1, 2, 3, 0};
    rst_              = 1'b1;
    bus.req           = '0;
    bus.req_dim       = '0;
    bus.eng_done      = 1'b0;
    bus.eng_out_valid = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    bus.eng_out_valid = 1'b0;
    rst_ = 1'b0;

    // Single requester 2, {l,n,m} = {3,2,4}
    set_dim(2, 4'd3, 4'd2, 4'd4);
    bus.req = 4'b0100;
    tick();
    check("single.gnt",   32'(bus.gnt),       32'h4);
    check("single.start", 32'(bus.eng_start), 32'h1);
    check("single.lnm",   32'({bus.eng_l, bus.eng_n, bus.eng_m}), 32'h324);
    tick();
    check("single.start_off", 32'(bus.eng_start), 32'h0);
    bus.eng_out_valid = 1'b1;
    #1;
    check("single.out_valid", 32'(bus.out_valid), 32'h4);
    bus.eng_out_valid = 1'b0;
    bus.eng_done      = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    bus.req      = '0;
    check("single.done", 32'(bus.done), 32'h4);
    check("single.err",  32'(bus.err),  32'h0);
    check("single.gnt_resp", 32'(bus.gnt), 32'h4);
    tick();
    check("single.gnt_idle", 32'(bus.gnt),  32'h0);
    check("single.done_off", 32'(bus.done), 32'h0);

    // All four requesters from reset: grant order 0,1,2,3,0
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    for (int r = 0; r < NREQ; r++) set_dim(r, 4'(r + 1), 4'(r + 2), 4'(r + 3));
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("rr%0d.gnt", j),   32'(bus.gnt),       32'(1 << order[j]));
      check($sformatf("rr%0d.start", j), 32'(bus.eng_start), 32'h1);
      check($sformatf("rr%0d.l", j),     32'(bus.eng_l),     32'(order[j] + 1));
      tick();
      check($sformatf("rr%0d.start_width", j), 32'(bus.eng_start), 32'h0);
      repeat (4) tick();
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      check($sformatf("rr%0d.done", j), 32'(bus.done), 32'(1 << order[j]));
      tick();
    end
    bus.req = '0;
    tick();
    check("rr.idle_gnt", 32'(bus.gnt), 32'h0);

    // Requester 1 with n=0 is rejected; requester 2 (also waiting) is next
    set_dim(1, 4'd2, 4'd0, 4'd3);
    set_dim(2, 4'd1, 4'd1, 4'd1);
    bus.req = 4'b0110;
    tick();
    check("zero.err",   32'(bus.err),       32'h2);
    check("zero.gnt",   32'(bus.gnt),       32'h2);
    check("zero.start", 32'(bus.eng_start), 32'h0);
    check("zero.done",  32'(bus.done),      32'h0);
    tick();
    check("zero.err_off", 32'(bus.err), 32'h0);
    check("zero.gnt_off", 32'(bus.gnt), 32'h0);
    tick();
    check("zero.next_gnt",   32'(bus.gnt),       32'h4);
    check("zero.next_start", 32'(bus.eng_start), 32'h1);
    bus.req = '0;

    // Requester 2 never sees eng_done: abort at r+TIMEOUT, err at r+TIMEOUT+1
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      check($sformatf("wdog.no_abort%0d", k), 32'(bus.eng_abort), 32'h0);
      tick();
    end
    check("wdog.abort",     32'(bus.eng_abort), 32'h1);
    check("wdog.err_early", 32'(bus.err),       32'h0);
    tick();
    check("wdog.err",       32'(bus.err),       32'h4);
    check("wdog.no_done",   32'(bus.done),      32'h0);
    check("wdog.abort_off", 32'(bus.eng_abort), 32'h0);
    tick();
    check("wdog.gnt_off", 32'(bus.gnt), 32'h0);

    // eng_done on the final watchdog cycle wins over abort
    set_dim(3, 4'd5, 4'd6, 4'd7);
    bus.req = 4'b1000;
    tick();
    check("edge.gnt", 32'(bus.gnt), 32'h8);
    tick();
    bus.req = '0;
    repeat (TIMEOUT - 1) tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    check("edge.done",     32'(bus.done),      32'h8);
    check("edge.no_abort", 32'(bus.eng_abort), 32'h0);
    check("edge.no_err",   32'(bus.err),       32'h0);
    tick();
    check("edge.no_err_after", 32'(bus.err), 32'h0);
    check("edge.gnt_off",      32'(bus.gnt), 32'h0);

    // Reset while running with eng_out_valid toggling
    set_dim(0, 4'd1, 4'd2, 4'd3);
    bus.req = 4'b0001;
    tick();
    check("rst.gnt", 32'(bus.gnt), 32'h1);
    tick();
    bus.req = '0;
    bus.eng_out_valid = 1'b1;
    #1;
    check("rst.out_valid", 32'(bus.out_valid), 32'h1);
    tick();
    bus.eng_out_valid = 1'b0;
    #1;
    check("rst.out_valid_low", 32'(bus.out_valid), 32'h0);
    rst_ = 1'b1;
    bus.eng_out_valid = 1'b1;
    tick();
    check_all_zero("rst_mid");
    rst_ = 1'b0;
    bus.eng_out_valid = 1'b0;
    bus.req = 4'b1111;
    tick();
    check("rst.first_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
